// File: rtl/calc_result_bcd.sv
// Captures a calculator result and converts it to packed BCD with a one-bit-per-cycle
// double-dabble engine. Define BCD_SIGNED_EN to show two's-complement results as sign + magnitude.
module calc_result_bcd #(
  parameter int         WIDTH     = 16,
  parameter int         DIGITS    = 5,
  parameter logic [3:0] ERR_DIGIT = 4'hE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [WIDTH-1:0]      in_result,
  input  logic                  in_div_by_zero,
  input  logic                  in_signed,
  output logic                  busy,
  output logic                  out_valid,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  neg,
  output logic                  err
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

  state_t              state;
  logic [WIDTH-1:0]    sh;
  logic [4*DIGITS-1:0] acc;
  logic [4*DIGITS-1:0] acc_adj;
  logic [CW-1:0]       cnt;
  logic                sign_q;
  logic                acc_sign;
  logic [WIDTH-1:0]    acc_mag;

`ifdef BCD_SIGNED_EN
  always_comb begin
    acc_sign = in_signed & in_result[WIDTH-1];
    acc_mag  = acc_sign ? (~in_result + 1'b1) : in_result;
  end
`else
  logic unused_signed;
  assign unused_signed = in_signed;
  always_comb begin
    acc_sign = 1'b0;
    acc_mag  = in_result;
  end
`endif

  // Pre-shift correction: any digit >= 5 would exceed 9 after doubling.
  always_comb begin
    acc_adj = acc;
    for (int i = 0; i < DIGITS; i++)
      if (acc[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      bcd       <= '0;
      neg       <= 1'b0;
      err       <= 1'b0;
      sh        <= '0;
      acc       <= '0;
      cnt       <= '0;
      sign_q    <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (in_div_by_zero) begin
              bcd       <= {DIGITS{ERR_DIGIT}};
              err       <= 1'b1;
              neg       <= 1'b0;
              out_valid <= 1'b1;
            end else begin
              sh     <= acc_mag;
              sign_q <= acc_sign;
              acc    <= '0;
              cnt    <= CW'(WIDTH);
              busy   <= 1'b1;
              state  <= SHIFT;
            end
          end
        end
        SHIFT: begin
          acc <= {acc_adj[4*DIGITS-2:0], sh[WIDTH-1]};
          sh  <= {sh[WIDTH-2:0], 1'b0};
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) state <= FINISH;
        end
        FINISH: begin
          bcd       <= acc;
          neg       <= sign_q;
          err       <= 1'b0;
          out_valid <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_result_bcd.sv
// Randomized self-checking bench for calc_result_bcd against a decimal-arithmetic reference.
module tb_calc_result_bcd;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_result;
  logic        in_div_by_zero;
  logic        in_signed;
  logic        busy;
  logic        out_valid;
  logic [19:0] bcd;
  logic        neg;
  logic        err;

  int checks = 0;
  int errors = 0;

  logic [19:0] prev_bcd = '0;
  logic        prev_neg = 1'b0;
  logic        prev_err = 1'b0;

  calc_result_bcd dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_result(in_result),
    .in_div_by_zero(in_div_by_zero), .in_signed(in_signed), .busy(busy),
    .out_valid(out_valid), .bcd(bcd), .neg(neg), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [19:0] to_bcd(input int m);
    logic [19:0] r;
    int p;
    r = '0;
    p = 1;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'((m / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  // One transaction: accept at E0, then watch edges E0..E24.
  // inj_at>0 pulses in_valid (value 999) at that edge; rst_at>0 asserts reset at that edge.
  task automatic run(input logic [15:0] val, input bit dz, input bit sg,
                     input int inj_at, input int rst_at);
    int pulses, first;
    int mag;
    bit eneg;
    logic [19:0] ebcd;
    logic eerr;
    pulses = 0;
    first  = -1;
    @(negedge clk);
    in_valid       = 1'b1;
    in_result      = val;
    in_div_by_zero = dz;
    in_signed      = sg;
    @(posedge clk);
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (out_valid) begin
        pulses++;
        if (first < 0) first = k;
      end
      if (k == 0) chk("busy_after_accept", busy, (!dz) ? 1 : 0);
      if (k == 5 && !dz && (rst_at == 0 || rst_at > 5)) begin
        chk("hold_bcd", bcd, prev_bcd);
        chk("hold_err", err, prev_err);
      end
      in_valid       = (k + 1 == inj_at);
      in_result      = (k + 1 == inj_at) ? 16'd999 : 16'($urandom);
      in_div_by_zero = 1'b0;
      in_signed      = 1'($urandom);
      rst            = (k + 1 == rst_at);
    end
    in_valid = 1'b0;
    rst      = 1'b0;

    if (rst_at > 0) begin
      ebcd = '0; eneg = 1'b0; eerr = 1'b0;
      chk("abort_pulses", pulses, 0);
    end else if (dz) begin
      ebcd = 20'hEEEEE; eneg = 1'b0; eerr = 1'b1;
      chk("pulses", pulses, 1);
      chk("latency_err", first, 0);
    end else begin
`ifdef BCD_SIGNED_EN
      eneg = sg && val[15];
`else
      eneg = 1'b0;
`endif
      mag  = eneg ? (65536 - int'(val)) : int'(val);
      ebcd = to_bcd(mag);
      eerr = 1'b0;
      chk("pulses", pulses, 1);
      chk("latency", first, 17);
    end
    chk("bcd", bcd, ebcd);
    chk("neg", neg, eneg);
    chk("err", err, eerr);
    chk("busy_idle", busy, 0);
    prev_bcd = ebcd;
    prev_neg = eneg;
    prev_err = eerr;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_result = '0; in_div_by_zero = 1'b0; in_signed = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_bcd", bcd, 0);
    chk("rst_neg", neg, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;

    run(16'd15,    0, 0, 0, 0);
    run(16'd65535, 0, 0, 0, 0);
    run(16'd0,     0, 0, 0, 0);
    run(16'd0,     1, 0, 0, 0);
    run(16'd50,    0, 0, 0, 0);
    run(16'd3,     0, 0, 5, 0);
    run(16'd1234,  0, 0, 0, 8);
    run(16'd42,    0, 0, 0, 0);
    run(16'hFFFB,  0, 1, 0, 0);
    run(16'h8000,  0, 1, 0, 0);
    run(16'h8000,  0, 0, 0, 0);

    for (int n = 0; n < 30; n++)
      run(16'($urandom), ($urandom_range(5) == 0), 1'($urandom), 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
